// File: rtl/alu_op_issuer.sv
// Initiator side of the ALU operand/flag interface: latches a request, drives the ALU,
// qualifies the result (condition, divide-by-zero, illegal op) and returns a held response.
module alu_op_issuer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    input  logic [3:0]   req_op,
    input  logic [2:0]   req_cond,
    input  logic         req_setf,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic [1:0]   rsp_status,
    output logic [3:0]   flag_q
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [1:0] STAT_OK    = 2'b00;
    localparam logic [1:0] STAT_SKIP  = 2'b01;
    localparam logic [1:0] STAT_DIV0  = 2'b10;
    localparam logic [1:0] STAT_ILLOP = 2'b11;

    // Flags are {N,Z,V,C}.
    function automatic logic cond_pass(input logic [2:0] cond, input logic [3:0] f);
        logic res;
        case (cond)
            3'b000:  res = 1'b1;
            3'b001:  res = f[2];
            3'b010:  res = ~f[2];
            3'b011:  res = f[3] ^ f[1];
            3'b100:  res = ~(f[3] ^ f[1]);
            3'b101:  res = f[3];
            3'b110:  res = f[1];
            3'b111:  res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]     op_q, op_d;
    logic [2:0]     cond_q, cond_d;
    logic           setf_q, setf_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_result_q, rsp_result_d;
    logic [3:0]     rsp_flags_q, rsp_flags_d;
    logic [1:0]     rsp_status_q, rsp_status_d;
    logic [3:0]     flag_d, flag_r;
    logic [1:0]     status_s;

    // Status priority: illegal op, then skipped condition, then divide/modulus by zero.
    always_comb begin
        status_s = STAT_OK;
        if (op_q >= 4'b1010) begin
            status_s = STAT_ILLOP;
        end else if (!cond_pass(cond_q, flag_r)) begin
            status_s = STAT_SKIP;
        end else if (((op_q == 4'b0100) || (op_q == 4'b1000)) && (b_q == {N{1'b0}})) begin
            status_s = STAT_DIV0;
        end else begin
            status_s = STAT_OK;
        end
    end

    // Next-state and datapath update for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        cond_d       = cond_q;
        setf_d       = setf_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_status_d = rsp_status_q;
        flag_d       = flag_r;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    cond_d  = req_cond;
                    setf_d  = req_setf;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_status_d = status_s;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
                // ALU output is discarded entirely unless the op really executed.
                if (status_s == STAT_OK) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    if (setf_q) begin
                        flag_d = alu_flags;
                    end else begin
                        flag_d = flag_r;
                    end
                end else begin
                    rsp_result_d = {N{1'b0}};
                    rsp_flags_d  = 4'b0000;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State, operand and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= {N{1'b0}};
            b_q          <= {N{1'b0}};
            op_q         <= 4'b0000;
            cond_q       <= 3'b000;
            setf_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= {N{1'b0}};
            rsp_flags_q  <= 4'b0000;
            rsp_status_q <= 2'b00;
            flag_r       <= 4'b0000;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            cond_q       <= cond_d;
            setf_q       <= setf_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_status_q <= rsp_status_d;
            flag_r       <= flag_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_status = rsp_status_q;
    assign flag_q     = flag_r;

endmodule
